// File: rtl/cam_pkg.sv
// Shared types for the DVP camera capture front-end: FSM states and the
// FIFO entry carried from byte assembly to the output stream.
package cam_pkg;

  // Entry fields are sized for the widest supported pixel and coordinate.
  localparam int CAM_DATA_W  = 24;
  localparam int CAM_COORD_W = 16;

  typedef enum logic [1:0] {
    SYNC_WAIT  = 2'd0,
    FRAME_WAIT = 2'd1,
    CAPTURE    = 2'd2
  } cam_state_t;

  typedef struct packed {
    logic [CAM_DATA_W-1:0]  data;
    logic [CAM_COORD_W-1:0] x;
    logic [CAM_COORD_W-1:0] y;
    logic                   sof;
    logic                   eol;
  } cam_entry_t;

endpackage

// File: rtl/cam_stream_fifo.sv
// Synchronous FIFO with a valid/ready read side. A write into a full FIFO
// is accepted when a read frees an entry on the same edge.
module cam_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  output logic             o_rd_valid,
  output logic [WIDTH-1:0] o_rd_data,
  input  logic             i_rd_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full     = (r_count == FULL_CNT);
  assign o_rd_valid = (r_count != '0);
  assign w_rd       = o_rd_valid & i_rd_ready;
  assign w_wr       = i_wr_en & (~o_full | w_rd);
  // Present zeros while empty so the stream outputs idle at a known value.
  assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/camera_capture.sv
// DVP camera capture: frame/line sync FSM, byte-to-pixel assembly with
// coordinate tracking and length checks, feeding a valid/ready output FIFO.
module camera_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE          = 640,
  parameter int V_ACTIVE          = 480,
  parameter int BYTES_PER_PIXEL   = 2,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1,
  parameter bit HREF_ACTIVE_HIGH  = 1'b1,
  parameter int FIFO_DEPTH        = 4,
  localparam int XW = $clog2(H_ACTIVE),
  localparam int YW = $clog2(V_ACTIVE),
  localparam int PW = 8 * BYTES_PER_PIXEL
) (
  input  logic          p_clock,
  input  logic          reset,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    p_data,
  output logic [PW-1:0] out_data,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_done,
  output logic [15:0]   frame_count,
  output logic          err_line,
  output logic          err_frame,
  output logic          overflow
);

  // Counters need one extra code so they can reach H_ACTIVE / V_ACTIVE.
  localparam int XCW = $clog2(H_ACTIVE + 1);
  localparam int YCW = $clog2(V_ACTIVE + 1);
  localparam int BIW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam logic [XCW-1:0] X_END  = XCW'(H_ACTIVE);
  localparam logic [XCW-1:0] X_LAST = XCW'(H_ACTIVE - 1);
  localparam logic [YCW-1:0] Y_END  = YCW'(V_ACTIVE);
  localparam logic [BIW-1:0] B_LAST = BIW'(BYTES_PER_PIXEL - 1);

  cam_state_t     r_state;
  logic           w_vs;
  logic           w_hr;
  logic           r_hr_prev;
  logic [XCW-1:0] r_x;
  logic [YCW-1:0] r_y;
  logic [BIW-1:0] r_byte_idx;
  logic [PW-1:0]  w_pix_next;
  logic           w_byte_en;
  logic           w_pix_done;
  logic           w_in_win;
  cam_entry_t     r_entry;
  cam_entry_t     w_head;
  logic           r_wr_en;
  logic           w_fifo_full;
  logic           w_rd_valid;
  logic           r_frame_done;
  logic [15:0]    r_frame_count;
  logic           r_err_line;
  logic           r_err_frame;
  logic           r_overflow;

  assign w_vs       = VSYNC_ACTIVE_HIGH ? vsync : ~vsync;
  assign w_hr       = HREF_ACTIVE_HIGH ? href : ~href;
  assign w_byte_en  = (r_state == CAPTURE) & ~w_vs & w_hr;
  assign w_pix_done = w_byte_en & (r_byte_idx == B_LAST);
  assign w_in_win   = (r_x < X_END) && (r_y < Y_END);

  // Stage 0: earlier bytes of the pixel wait here, first byte ends up as MSB.
  generate
    if (BYTES_PER_PIXEL == 1) begin : g_one_byte
      assign w_pix_next = p_data;
    end else begin : g_multi_byte
      logic [PW-9:0] r_pix;
      always_ff @(posedge p_clock) begin
        if (w_byte_en) r_pix <= w_pix_next[PW-9:0];
      end
      assign w_pix_next = {r_pix, p_data};
    end
  endgenerate

  always_ff @(posedge p_clock) begin
    if (reset) begin
      r_state       <= SYNC_WAIT;
      r_hr_prev     <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_byte_idx    <= '0;
      r_wr_en       <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_err_line    <= 1'b0;
      r_err_frame   <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_hr_prev    <= w_hr;
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      if (r_wr_en && w_fifo_full && !(out_valid && out_ready)) r_overflow <= 1'b1;
      case (r_state)
        SYNC_WAIT: begin
          if (w_vs) r_state <= FRAME_WAIT;
        end
        FRAME_WAIT: begin
          if (!w_vs) begin
            r_state     <= CAPTURE;
            r_x         <= '0;
            r_y         <= '0;
            r_byte_idx  <= '0;
            r_err_line  <= 1'b0;
            r_err_frame <= 1'b0;
            r_overflow  <= 1'b0;
          end
        end
        CAPTURE: begin
          if (w_vs) begin
            r_state       <= FRAME_WAIT;
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            if (r_y != Y_END) r_err_frame <= 1'b1;
          end else if (w_hr) begin
            if (r_byte_idx == B_LAST) begin
              r_byte_idx <= '0;
              if (w_in_win) begin
                r_wr_en <= 1'b1;
                r_x     <= r_x + XCW'(1);
              end else begin
                r_err_line <= 1'b1;
                if (r_x != X_END) r_x <= r_x + XCW'(1);
              end
            end else begin
              r_byte_idx <= r_byte_idx + BIW'(1);
            end
          end else if (r_hr_prev) begin
            if (r_byte_idx != '0 || r_x != X_END) r_err_line <= 1'b1;
            r_x        <= '0;
            r_byte_idx <= '0;
            if (r_y != Y_END) r_y <= r_y + YCW'(1);
          end
        end
        default: r_state <= SYNC_WAIT;
      endcase
    end
  end

  // Stage 1: completed pixel and its markers, written to the FIFO next edge.
  always_ff @(posedge p_clock) begin
    if (w_pix_done) begin
      r_entry.data <= CAM_DATA_W'(w_pix_next);
      r_entry.x    <= CAM_COORD_W'(r_x);
      r_entry.y    <= CAM_COORD_W'(r_y);
      r_entry.sof  <= (r_x == '0) && (r_y == '0);
      r_entry.eol  <= (r_x == X_LAST);
    end
  end

  cam_stream_fifo #(
    .WIDTH ($bits(cam_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (p_clock),
    .i_rst      (reset),
    .i_wr_en    (r_wr_en),
    .i_wr_data  (r_entry),
    .o_full     (w_fifo_full),
    .o_rd_valid (w_rd_valid),
    .o_rd_data  (w_head),
    .i_rd_ready (out_ready)
  );

  assign out_valid   = w_rd_valid;
  assign out_data    = PW'(w_head.data);
  assign out_x       = XW'(w_head.x);
  assign out_y       = YW'(w_head.y);
  assign out_sof     = w_head.sof;
  assign out_eol     = w_head.eol;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign err_line    = r_err_line;
  assign err_frame   = r_err_frame;
  assign overflow    = r_overflow;

endmodule

// File: doc/camera_capture.md
# camera_capture

Parametrised DVP camera capture front-end: samples the sensor's byte-serial bus (`vsync`, `href`, `p_data`) on the pixel clock and assembles `BYTES_PER_PIXEL` bytes into one pixel. Each pixel goes out with its coordinates and frame/line markers through a valid/ready stream backed by a small FIFO. It replaces the fixed 640x480 RGB565 capture path between the sensor pins and the frame-buffer writer. It adds sync-polarity options, per-line and per-frame length checking, backpressure with overflow detection, and a frame counter.

## Interface
- `H_ACTIVE`, 640, pixels per line
- `V_ACTIVE`, 480, lines per frame
- `BYTES_PER_PIXEL`, 2, bytes per pixel, 1..3; the first byte received is the MSB
- `VSYNC_ACTIVE_HIGH`, 1, vsync polarity
- `HREF_ACTIVE_HIGH`, 1, href polarity
- `FIFO_DEPTH`, 4, output FIFO entries, power of 2, >=2
- Derived widths: `XW = $clog2(H_ACTIVE)`, `YW = $clog2(V_ACTIVE)`, `PW = 8*BYTES_PER_PIXEL`
- `p_clock  in  1  pixel clock`; the only clock
- `reset  in  1  synchronous, active-high reset`
- `vsync  in  1  frame sync, polarity per parameter`
- `href  in  1  line-valid, polarity per parameter`
- `p_data  in  8  sensor byte`
- `out_data  out  PW  assembled pixel`
- `out_x  out  XW  column of pixel`
- `out_y  out  YW  row of pixel`
- `out_sof  out  1  pixel (0,0)`
- `out_eol  out  1  pixel x = H_ACTIVE-1`
- `out_valid  out  1  stream valid`
- `out_ready  in  1  stream ready`
- `frame_done  out  1  one-cycle pulse at frame end`
- `frame_count  out  16  completed frames, wraps at 0xFFFF -> 0`
- `err_line  out  1  sticky: line with wrong byte or pixel count`
- `err_frame  out  1  sticky: frame with line count != V_ACTIVE`
- `overflow  out  1  sticky: pixel dropped because the FIFO was full`

## Operation
- Internal `vs`/`hr` signals are the inputs normalised to active-high. `hr_prev` is registered.
- FSM has 3 states:
  - `SYNC_WAIT`: waits for `vs`=1, then goes to `FRAME_WAIT`. This discards the partial frame after reset.
  - `FRAME_WAIT`: waits for `vs`=0. On entry to `CAPTURE`, clears x, y, byte_idx and the sticky flags.
  - `CAPTURE`: captures pixels. `vs`=1 goes to `FRAME_WAIT`, pulses `frame_done`, increments `frame_count`, and sets `err_frame` if y != V_ACTIVE.
- Byte assembly happens in `CAPTURE` while `hr`=1:
  - The byte is shifted into the pixel register and byte_idx increments.
  - When byte_idx = BYTES_PER_PIXEL-1, the pixel completes and byte_idx returns to 0.
  - A completed pixel with x < H_ACTIVE and y < V_ACTIVE is written to the FIFO, then x increments.
  - A completed pixel outside that window is not written, sets `err_line`, and x saturates.
- Falling edge of href (`hr_prev`=1, `hr`=0):
  - Sets `err_line` if byte_idx != 0 or x != H_ACTIVE.
  - x and byte_idx reset to 0.
  - y increments, saturating at V_ACTIVE.
- FIFO full at a pixel write: the pixel is dropped, `overflow` is set, and x still advances so later coordinates stay correct.
- Sticky flags hold their value from the end of a frame until the start of the next capture.
- `out_valid`/`out_ready` follow AXI-stream rules: a beat transfers when both are high; data is stable while valid and not ready.
- `reset`: all state is cleared and the FSM goes to `SYNC_WAIT`, including mid-frame; the FIFO is flushed.
- Output reset values: `out_valid`=0, `out_data`/`out_x`/`out_y`/`out_sof`/`out_eol`=0, `frame_done`=0, `frame_count`=0, all error flags 0.

## Timing
- Latency: the last byte of a pixel is sampled at edge N; `out_valid` is high after edge N+1 when the FIFO was empty.
- FIFO write and read in the same cycle are both allowed, including when the FIFO is full; the write succeeds because the read frees an entry.
- `frame_done` is high for exactly the cycle after the edge that samples the `vs` rise in `CAPTURE`.
- `vs` asserting mid-line ends the frame immediately; that line is not counted in y.
- `href` must not be acted on in `SYNC_WAIT` or `FRAME_WAIT`: no writes, no counting.
- Pixels already queued in the FIFO still drain after the frame ends.

## Structure
- Package `cam_pkg` holds the FSM state enum (`SYNC_WAIT`, `FRAME_WAIT`, `CAPTURE`) and the FIFO entry struct (data, x, y, sof, eol).
- Sub-module `cam_stream_fifo` is a parametrised synchronous FIFO with width, depth, full/empty and a valid/ready read side.
- The capture FSM and byte assembly stay in `camera_capture`.

## Test plan
- Sensor model, 8x4 frame, BYTES_PER_PIXEL=2, `out_ready`=1: 32 beats; first beat `out_sof`=1, x=0, y=0; beats at x=7 have `out_eol`=1; bytes 0xAB,0xCD -> `out_data`=0xABCD; `frame_done` pulses once; `frame_count`=1.
- Reset released mid-frame: no output until after the next `vs` pulse; the first full frame is then captured complete.
- `out_ready` held low, FIFO_DEPTH=4, 8-pixel line: 4 beats retained, `overflow`=1, x/y of the retained beats are 0..3; releasing ready drains exactly 4 beats.
- Line of 7 pixels, then a line with 15 bytes at BPP=2: `err_line`=1 on both; the following frame starts with the flags cleared.
- Frame of 3 lines with V_ACTIVE=4: `err_frame`=1 after `frame_done`.
- VSYNC_ACTIVE_HIGH=0, HREF_ACTIVE_HIGH=0, BPP=3 with inverted stimulus: `out_data`=24-bit pixels in byte order; `frame_count` wraps from 0xFFFF to 0 after preload by force.
